// File: rtl/adder_arb_pkg.sv
// Shared types and the round-robin pick function for adder_arbiter.
package adder_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } arb_state_e;

  // Widest requester vector rr_pick can search (NREQ must not exceed this).
  localparam int MAX_REQ = 64;
  localparam int PIW     = 6;
  localparam int PW      = 7;

  typedef struct packed {
    logic           found;
    logic [PIW-1:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, wrapping at nreq.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [PW-1:0]      ptr,
                                       input logic [PW-1:0]      nreq);
    rr_pick_t       p;
    logic [PW-1:0]  idx;
    logic           hit;
    p.found = 1'b0;
    p.idx   = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx     = ((ptr + PW'(k)) >= nreq) ? (ptr + PW'(k) - nreq) : (ptr + PW'(k));
      hit     = (PW'(k) < nreq) && !p.found && valid[idx[PIW-1:0]];
      p.idx   = hit ? idx[PIW-1:0] : p.idx;
      p.found = p.found | hit;
    end
    return p;
  endfunction

endpackage

// File: rtl/adder.sv
// Registered adder: x + y + cin, truncated or zero-extended to SWIDTH, with a zero flag.
module adder #(
  parameter int SWIDTH = 9,
  parameter int WIDTH  = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [WIDTH-1:0]  i_x,
  input  logic [WIDTH-1:0]  i_y,
  input  logic              i_cin,
  output logic [SWIDTH-1:0] o_sm,
  output logic [SWIDTH-1:0] o_sm_r,
  output logic              o_sm_zero_r
);

  localparam int FW = (SWIDTH > WIDTH + 1) ? SWIDTH : WIDTH + 1;

  logic [FW-1:0] w_full;

  assign w_full = FW'(i_x) + FW'(i_y) + FW'(i_cin);
  assign o_sm   = SWIDTH'(w_full);

  // Capture sum and zero flag every cycle; inputs are held static while a result waits.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sm_r      <= '0;
      o_sm_zero_r <= 1'b0;
    end else begin
      o_sm_r      <= o_sm;
      o_sm_zero_r <= (o_sm == '0);
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin front end sharing one registered adder between NREQ requesters,
// one operation in flight, result tagged with the owner's ID.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int WIDTH  = 8,
  parameter int SWIDTH = WIDTH + 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [NREQ-1:0]       i_req_valid,
  output logic [NREQ-1:0]       o_req_ready,
  input  logic [NREQ*WIDTH-1:0] i_req_x,
  input  logic [NREQ*WIDTH-1:0] i_req_y,
  input  logic [NREQ-1:0]       i_req_cin,
  output logic                  o_resp_valid,
  input  logic                  i_resp_ready,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] o_resp_id,
  output logic [SWIDTH-1:0]     o_resp_sum,
  output logic                  o_resp_zero
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e        r_state;
  arb_state_e        w_state_nxt;
  logic [IDW-1:0]    r_rr_ptr;
  logic [WIDTH-1:0]  r_op_x;
  logic [WIDTH-1:0]  r_op_y;
  logic              r_op_cin;
  logic [IDW-1:0]    r_op_id;

  rr_pick_t          w_pick;
  logic [IDW-1:0]    w_win;
  logic              w_open;
  logic              w_accept;
  logic [SWIDTH-1:0] w_sm_unused;
  logic [SWIDTH-1:0] w_sm_r;
  logic              w_sm_zero_r;

  assign w_pick   = rr_pick(MAX_REQ'(i_req_valid), PW'(r_rr_ptr), PW'(NREQ));
  assign w_win    = IDW'(w_pick.idx);
  // Ready is withheld during reset so no requester sees a phantom grant.
  assign w_accept = i_rst_n && w_open && w_pick.found;

  assign o_req_ready  = w_accept ? (NREQ'(1'b1) << w_win) : NREQ'(1'b0);
  assign o_resp_valid = (r_state == DONE);
  assign o_resp_id    = r_op_id;
  assign o_resp_sum   = w_sm_r;
  assign o_resp_zero  = w_sm_zero_r;

  // Grant window and next state.
  always_comb begin
    w_open      = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        w_open      = 1'b1;
        w_state_nxt = w_accept ? CALC : IDLE;
      end
      CALC: begin
        w_open      = 1'b0;
        w_state_nxt = DONE;
      end
      DONE: begin
        w_open = i_resp_ready;
        if (i_resp_ready) begin
          w_state_nxt = w_accept ? CALC : IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_open      = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State, round-robin pointer and operand capture on accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_rr_ptr <= '0;
      r_op_x   <= '0;
      r_op_y   <= '0;
      r_op_cin <= 1'b0;
      r_op_id  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_rr_ptr <= (w_win == IDW'(NREQ - 1)) ? IDW'(0) : (w_win + IDW'(1));
        r_op_x   <= i_req_x[int'(w_win)*WIDTH +: WIDTH];
        r_op_y   <= i_req_y[int'(w_win)*WIDTH +: WIDTH];
        r_op_cin <= i_req_cin[w_win];
        r_op_id  <= w_win;
      end
    end
  end

  adder #(
    .SWIDTH (SWIDTH),
    .WIDTH  (WIDTH)
  ) u_adder (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_x         (r_op_x),
    .i_y         (r_op_y),
    .i_cin       (r_op_cin),
    .o_sm        (w_sm_unused),
    .o_sm_r      (w_sm_r),
    .o_sm_zero_r (w_sm_zero_r)
  );

endmodule
